cpu_seq_ctl: RTL and testbench
==============================

// Module: cpu_seq_ctl
// PURPOSE
//  Instruction-cycle controller for the simple RISC CPU. Runs one 8-cycle sequence per instruction
//  and drives the datapath strobes: IR load, PC increment/load, ACC load, memory rd/wr, bus drive, halt.
//  Sits beside clk_gen; its ena is clk_gen.fetch and its clk is clk_gen.clk.
//  Opcode comes from the instruction register; zero comes from the accumulator.
// PARAMETERS
//  OPC_W        3   opcode width; the encodings below assume 3
//  HALT_STICKY  1   1: after HLT, stay in HALTED until rst. 0: halt pulses for one cycle, then the sequence continues
// PORTS
//  clk          in   1      CPU clock; all state changes on the rising edge
//  rst          in   1      synchronous, active-high reset
//  ena          in   1      start enable (clk_gen.fetch); sampled only in IDLE and in S7
//  opcode       in   OPC_W  IR[15:13]; valid from S2 onward
//  zero         in   1      accumulator == 0
//  load_ir      out  1      IR captures the data bus (one byte per cycle)
//  inc_pc       out  1      PC += 1
//  load_pc      out  1      PC <= IR address field
//  load_acc     out  1      ACC <= ALU result
//  rd           out  1      memory read strobe
//  wr           out  1      memory write strobe
//  datactl_ena  out  1      drive ALU output onto the data bus
//  halt         out  1      CPU halted
//  instr_done   out  1      one-cycle pulse in S7 of each completed instruction
//  state_o      out  4      current state, for debug
// BEHAVIOUR
//  - States: IDLE, S0..S7, HALTED. Encoding lives in the package.
//  - Reset: state = IDLE, opc_q = 0, zero_q = 0. All outputs are 0 in the cycle after rst is sampled high.
//  - Outputs are a combinational decode of (state, opc_q, zero_q). No output is ever X.
//  - Transitions:
//    - IDLE -> S0 when ena = 1; otherwise stay in IDLE.
//    - S0 -> S1 -> S2 -> S3 -> S4 -> S5 -> S6 -> S7 unconditionally.
//    - S7 -> S0 when ena = 1; otherwise S7 -> IDLE.
//    - S3 -> HALTED when opc_q = HLT and HALT_STICKY = 1.
//    - HALTED is left only by rst.
//  - Captures: opc_q <= opcode on S2 entry. zero_q <= zero on S4 entry (before any ACC update).
//    Later changes on opcode or zero have no effect within the same instruction.
//  - Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
//  - Per-state outputs; anything not listed is 0:
//    - S0, S1: rd, load_ir, inc_pc (fetch instruction hi byte, then lo byte).
//    - S2: none.
//    - S3: halt if HLT.
//    - S4: rd if ADD/AND/XOR/LDA; datactl_ena if STO; load_pc if JMP.
//    - S5: rd and load_acc if ADD/AND/XOR/LDA; datactl_ena and wr if STO; load_pc if JMP;
//          inc_pc if SKZ and zero_q.
//    - S6: datactl_ena if STO.
//    - S7: inc_pc if SKZ and zero_q; instr_done always.
//    - HALTED: halt = 1.
//  - Invariants: wr = 1 implies datactl_ena = 1 in the same cycle. rd and wr are never both 1.
//  - Latency: 8 cycles per instruction, back to back while ena = 1.
//  - rst mid-sequence: return to IDLE on the next edge. A partial instruction is discarded, no strobes.
//  - ena dropping inside S0..S6 is ignored; the instruction completes.
//  - Illegal state encoding: next state is IDLE, outputs are 0.
// STRUCTURE
//  - cpu_pkg holds the opcode localparams (HLT..JMP) and the state encodings.
//  - One combinational sub-module, cpu_seq_dec: (state, opc_q, zero_q) -> strobe vector.
//  - The FSM and the capture registers stay in the top.
// TESTING
//  1. rst=1 for 2 cycles, then ena=0 for 5 cycles
//     -> state_o = IDLE throughout, all strobes 0.
//  2. ena=1, opcode=LDA (101)
//     -> S0/S1 rd, load_ir, inc_pc; S4 rd; S5 rd and load_acc; instr_done in cycle 8; next cycle is S0.
//  3. opcode=STO (110)
//     -> datactl_ena in S4..S6; wr only in S5; rd is 0 in S2..S7.
//  4. opcode=SKZ with zero=1 at S4, then zero toggled to 0 in S5
//     -> inc_pc in S5 and S7 (captured value used).
//     Repeat with zero=0 -> no inc_pc after S1.
//  5. opcode=HLT, HALT_STICKY=1
//     -> HALTED after S3, halt stays 1 for 20+ cycles, then rst returns to IDLE.
//     With HALT_STICKY=0 -> halt pulses once in S3 only.
//  6. rst asserted in S5 of ADD
//     -> IDLE next cycle, no load_acc.
//     ena dropped in S3 -> instruction completes, then IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU instruction-cycle controller: opcodes, FSM states, strobe bundle.
package cpu_pkg;

    localparam int ST_W = 4;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [ST_W-1:0] ST_IDLE   = 4'd0;
    localparam logic [ST_W-1:0] ST_S0     = 4'd1;
    localparam logic [ST_W-1:0] ST_S1     = 4'd2;
    localparam logic [ST_W-1:0] ST_S2     = 4'd3;
    localparam logic [ST_W-1:0] ST_S3     = 4'd4;
    localparam logic [ST_W-1:0] ST_S4     = 4'd5;
    localparam logic [ST_W-1:0] ST_S5     = 4'd6;
    localparam logic [ST_W-1:0] ST_S6     = 4'd7;
    localparam logic [ST_W-1:0] ST_S7     = 4'd8;
    localparam logic [ST_W-1:0] ST_HALTED = 4'd9;

    typedef struct packed {
        logic load_ir;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic rd;
        logic wr;
        logic datactl_ena;
        logic halt;
        logic instr_done;
    } strobe_t;

    // Opcodes that read a memory operand into the ALU.
    function automatic logic is_mem_rd(input logic [2:0] opc);
        return (opc == OP_ADD) || (opc == OP_AND) || (opc == OP_XOR) || (opc == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_seq_dec.sv
// Combinational strobe decode from (state, captured opcode, captured zero); zero latency, no flow control.
// Unlisted and illegal states decode to all-zero strobes.
module cpu_seq_dec
    import cpu_pkg::*;
(
    input  logic [ST_W-1:0] i_state,
    input  logic [2:0]      i_opc,
    input  logic            i_zero,
    output strobe_t         o_strb
);

    logic w_mem_rd;
    logic w_sto;
    logic w_jmp;
    logic w_skip;

    assign w_mem_rd = is_mem_rd(i_opc);
    assign w_sto    = (i_opc == OP_STO);
    assign w_jmp    = (i_opc == OP_JMP);
    assign w_skip   = (i_opc == OP_SKZ) && i_zero;

    always_comb begin
        o_strb = '0;
        case (i_state)
            ST_S0, ST_S1: begin
                o_strb.rd      = 1'b1;
                o_strb.load_ir = 1'b1;
                o_strb.inc_pc  = 1'b1;
            end
            ST_S3: o_strb.halt = (i_opc == OP_HLT);
            ST_S4: begin
                o_strb.rd          = w_mem_rd;
                o_strb.datactl_ena = w_sto;
                o_strb.load_pc     = w_jmp;
            end
            ST_S5: begin
                o_strb.rd          = w_mem_rd;
                o_strb.load_acc    = w_mem_rd;
                o_strb.datactl_ena = w_sto;
                o_strb.wr          = w_sto;
                o_strb.load_pc     = w_jmp;
                o_strb.inc_pc      = w_skip;
            end
            ST_S6: o_strb.datactl_ena = w_sto;
            ST_S7: begin
                o_strb.inc_pc     = w_skip;
                o_strb.instr_done = 1'b1;
            end
            ST_HALTED: o_strb.halt = 1'b1;
            default: o_strb = '0;
        endcase
    end

endmodule

// File: rtl/cpu_seq_ctl.sv
// Instruction-cycle controller: one 8-state sequence per instruction, back to back while ena holds.
// ena is only looked at in IDLE and S7; HALTED (sticky mode) is left only through rst.
module cpu_seq_ctl
    import cpu_pkg::*;
#(
    parameter int OPC_W       = 3,
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_acc,
    output logic             rd,
    output logic             wr,
    output logic             datactl_ena,
    output logic             halt,
    output logic             instr_done,
    output logic [3:0]       state_o
);

    logic [ST_W-1:0]  r_state;
    logic [OPC_W-1:0] r_opc;
    logic             r_zero;
    logic [ST_W-1:0]  w_state_nxt;
    strobe_t          w_strb;

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_state_nxt = ena ? ST_S0 : ST_IDLE;
            ST_S0:     w_state_nxt = ST_S1;
            ST_S1:     w_state_nxt = ST_S2;
            ST_S2:     w_state_nxt = ST_S3;
            ST_S3:     w_state_nxt = (HALT_STICKY && (r_opc == OP_HLT)) ? ST_HALTED : ST_S4;
            ST_S4:     w_state_nxt = ST_S5;
            ST_S5:     w_state_nxt = ST_S6;
            ST_S6:     w_state_nxt = ST_S7;
            ST_S7:     w_state_nxt = ena ? ST_S0 : ST_IDLE;
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Opcode is latched on S2 entry, zero on S4 entry, so later input changes cannot disturb the instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_opc   <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_S1) begin
                r_opc <= opcode;
            end
            if ((r_state == ST_S3) && (w_state_nxt == ST_S4)) begin
                r_zero <= zero;
            end
        end
    end

    cpu_seq_dec u_dec (
        .i_state (r_state),
        .i_opc   (r_opc),
        .i_zero  (r_zero),
        .o_strb  (w_strb)
    );

    assign load_ir     = w_strb.load_ir;
    assign inc_pc      = w_strb.inc_pc;
    assign load_pc     = w_strb.load_pc;
    assign load_acc    = w_strb.load_acc;
    assign rd          = w_strb.rd;
    assign wr          = w_strb.wr;
    assign datactl_ena = w_strb.datactl_ena;
    assign halt        = w_strb.halt;
    assign instr_done  = w_strb.instr_done;
    assign state_o     = r_state;

endmodule

// File: tb/tb_cpu_seq_ctl.sv
// Directed bench for cpu_seq_ctl: a sticky-halt instance plus a pulse-halt instance sharing stimulus.
module tb_cpu_seq_ctl;
    import cpu_pkg::*;

    localparam logic [8:0] M_IR   = 9'h100;
    localparam logic [8:0] M_INC  = 9'h080;
    localparam logic [8:0] M_LPC  = 9'h040;
    localparam logic [8:0] M_LACC = 9'h020;
    localparam logic [8:0] M_RD   = 9'h010;
    localparam logic [8:0] M_WR   = 9'h008;
    localparam logic [8:0] M_DCT  = 9'h004;
    localparam logic [8:0] M_HLT  = 9'h002;
    localparam logic [8:0] M_DONE = 9'h001;
    localparam logic [8:0] M_F    = M_IR | M_INC | M_RD;
    localparam logic [8:0] M_0    = 9'h000;

    logic       clk = 1'b0;
    logic       rst, ena, zero;
    logic [2:0] opcode;

    logic       load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt, instr_done;
    logic [3:0] state_o;
    logic       n_load_ir, n_inc_pc, n_load_pc, n_load_acc, n_rd, n_wr, n_datactl_ena, n_halt, n_instr_done;
    logic [3:0] n_state_o;
    logic [8:0] obs, n_obs;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_seq_ctl #(.OPC_W(3), .HALT_STICKY(1'b1)) dut (
        .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
        .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc),
        .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt),
        .instr_done(instr_done), .state_o(state_o)
    );

    cpu_seq_ctl #(.OPC_W(3), .HALT_STICKY(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
        .load_ir(n_load_ir), .inc_pc(n_inc_pc), .load_pc(n_load_pc), .load_acc(n_load_acc),
        .rd(n_rd), .wr(n_wr), .datactl_ena(n_datactl_ena), .halt(n_halt),
        .instr_done(n_instr_done), .state_o(n_state_o)
    );

    assign obs   = {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt, instr_done};
    assign n_obs = {n_load_ir, n_inc_pc, n_load_pc, n_load_acc, n_rd, n_wr, n_datactl_ena,
                    n_halt, n_instr_done};

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ena = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b0; zero = 1'b1; opcode = OP_JMP;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (state_o !== ST_IDLE || obs !== M_0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d state=%0d strb=%b want state=%0d strb=%b",
                         i, state_o, obs, ST_IDLE, M_0);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if (state_o !== ST_IDLE || obs !== M_0) begin
                n_bad++;
                $display("FAIL idle_no_ena cyc=%0d state=%0d strb=%b want state=%0d strb=%b",
                         i, state_o, obs, ST_IDLE, M_0);
            end
        end
    endtask

    task automatic test_lda();
        logic [8:0] exp [8];
        logic [3:0] est;
        exp = '{M_F, M_F, M_0, M_0, M_RD, M_RD | M_LACC, M_0, M_DONE};
        do_reset();
        opcode = OP_LDA; zero = 1'b0; ena = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 3) opcode = OP_STO;
            est = ST_S0 + 4'(i);
            n_chk++;
            if (state_o !== est || obs !== exp[i]) begin
                n_bad++;
                $display("FAIL lda step=%0d state=%0d strb=%b want state=%0d strb=%b",
                         i, state_o, obs, est, exp[i]);
            end
        end
        tick();
        n_chk++;
        if (state_o !== ST_S0 || obs !== M_F) begin
            n_bad++;
            $display("FAIL back_to_back state=%0d strb=%b want state=%0d strb=%b",
                     state_o, obs, ST_S0, M_F);
        end
    endtask

    task automatic test_sto();
        logic [8:0] exp [8];
        logic [3:0] est;
        exp = '{M_F, M_F, M_0, M_0, M_DCT, M_DCT | M_WR, M_DCT, M_DONE};
        do_reset();
        opcode = OP_STO; ena = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 2) ena = 1'b0;
            est = ST_S0 + 4'(i);
            n_chk++;
            if (state_o !== est || obs !== exp[i]) begin
                n_bad++;
                $display("FAIL sto step=%0d state=%0d strb=%b want state=%0d strb=%b",
                         i, state_o, obs, est, exp[i]);
            end
            n_chk++;
            if ((wr && !datactl_ena) || (rd && wr)) begin
                n_bad++;
                $display("FAIL sto_invariant step=%0d rd=%b wr=%b dct=%b want wr->dct and !(rd&wr)",
                         i, rd, wr, datactl_ena);
            end
        end
        tick();
        n_chk++;
        if (state_o !== ST_IDLE || obs !== M_0) begin
            n_bad++;
            $display("FAIL sto_to_idle state=%0d strb=%b want state=%0d strb=%b",
                     state_o, obs, ST_IDLE, M_0);
        end
    endtask

    task automatic test_skz();
        logic [8:0] exp [8];
        logic [3:0] est;
        for (int p = 0; p < 2; p++) begin
            if (p == 0) exp = '{M_F, M_F, M_0, M_0, M_0, M_INC, M_0, M_INC | M_DONE};
            else        exp = '{M_F, M_F, M_0, M_0, M_0, M_0, M_0, M_DONE};
            do_reset();
            opcode = OP_SKZ; zero = (p == 0); ena = 1'b1;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (i == 4) zero = (p != 0);
                if (i == 6) ena = 1'b0;
                est = ST_S0 + 4'(i);
                n_chk++;
                if (state_o !== est || obs !== exp[i]) begin
                    n_bad++;
                    $display("FAIL skz zero_at_s4=%0d step=%0d state=%0d strb=%b want state=%0d strb=%b",
                             (p == 0), i, state_o, obs, est, exp[i]);
                end
            end
        end
    endtask

    task automatic test_halt();
        logic [8:0] n_exp [8];
        logic [3:0] est;
        n_exp = '{M_F, M_F, M_0, M_HLT, M_0, M_0, M_0, M_DONE};
        do_reset();
        opcode = OP_HLT; zero = 1'b0; ena = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 6) ena = 1'b0;
            est = ST_S0 + 4'(i);
            n_chk++;
            if (n_state_o !== est || n_obs !== n_exp[i]) begin
                n_bad++;
                $display("FAIL halt_pulse step=%0d state=%0d strb=%b want state=%0d strb=%b",
                         i, n_state_o, n_obs, est, n_exp[i]);
            end
            if (i >= 4) est = ST_HALTED;
            n_chk++;
            if (state_o !== est || obs !== ((i < 3) ? n_exp[i] : M_HLT)) begin
                n_bad++;
                $display("FAIL halt_enter step=%0d state=%0d strb=%b want state=%0d strb=%b",
                         i, state_o, obs, est, (i < 3) ? n_exp[i] : M_HLT);
            end
        end
        for (int j = 0; j < 22; j++) begin
            tick();
            if (j == 0) begin
                n_chk++;
                if (n_state_o !== ST_IDLE || n_obs !== M_0) begin
                    n_bad++;
                    $display("FAIL halt_pulse_idle state=%0d strb=%b want state=%0d strb=%b",
                             n_state_o, n_obs, ST_IDLE, M_0);
                end
            end
            ena = j[0];
            n_chk++;
            if (state_o !== ST_HALTED || obs !== M_HLT) begin
                n_bad++;
                $display("FAIL halt_sticky cyc=%0d state=%0d strb=%b want state=%0d strb=%b",
                         j, state_o, obs, ST_HALTED, M_HLT);
            end
        end
        rst = 1'b1; ena = 1'b0;
        tick();
        rst = 1'b0;
        n_chk++;
        if (state_o !== ST_IDLE || obs !== M_0) begin
            n_bad++;
            $display("FAIL halt_rst state=%0d strb=%b want state=%0d strb=%b",
                     state_o, obs, ST_IDLE, M_0);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        opcode = OP_ADD; zero = 1'b0; ena = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_chk++;
        if (state_o !== ST_S5 || obs !== (M_RD | M_LACC)) begin
            n_bad++;
            $display("FAIL add_s5 state=%0d strb=%b want state=%0d strb=%b",
                     state_o, obs, ST_S5, M_RD | M_LACC);
        end
        rst = 1'b1;
        tick();
        n_chk++;
        if (state_o !== ST_IDLE || obs !== M_0) begin
            n_bad++;
            $display("FAIL rst_mid state=%0d strb=%b want state=%0d strb=%b",
                     state_o, obs, ST_IDLE, M_0);
        end
        rst = 1'b0; ena = 1'b0;
        tick();
        n_chk++;
        if (state_o !== ST_IDLE || obs !== M_0) begin
            n_bad++;
            $display("FAIL rst_mid_after state=%0d strb=%b want state=%0d strb=%b",
                     state_o, obs, ST_IDLE, M_0);
        end
    endtask

    task automatic test_ena_drop();
        logic [8:0] exp [8];
        logic [3:0] est;
        exp = '{M_F, M_F, M_0, M_0, M_RD, M_RD | M_LACC, M_0, M_DONE};
        do_reset();
        opcode = OP_ADD; ena = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 3) ena = 1'b0;
            est = ST_S0 + 4'(i);
            n_chk++;
            if (state_o !== est || obs !== exp[i]) begin
                n_bad++;
                $display("FAIL ena_drop step=%0d state=%0d strb=%b want state=%0d strb=%b",
                         i, state_o, obs, est, exp[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (state_o !== ST_IDLE || obs !== M_0) begin
                n_bad++;
                $display("FAIL ena_drop_idle cyc=%0d state=%0d strb=%b want state=%0d strb=%b",
                         i, state_o, obs, ST_IDLE, M_0);
            end
        end
    endtask

    task automatic test_jmp();
        logic [8:0] exp [8];
        logic [3:0] est;
        exp = '{M_F, M_F, M_0, M_0, M_LPC, M_LPC, M_0, M_DONE};
        do_reset();
        opcode = OP_JMP; ena = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 6) ena = 1'b0;
            est = ST_S0 + 4'(i);
            n_chk++;
            if (state_o !== est || obs !== exp[i]) begin
                n_bad++;
                $display("FAIL jmp step=%0d state=%0d strb=%b want state=%0d strb=%b",
                         i, state_o, obs, est, exp[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: bench did not reach summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ena = 1'b0; zero = 1'b0; opcode = OP_HLT;
        test_reset();
        test_lda();
        test_sto();
        test_skz();
        test_jmp();
        test_halt();
        test_rst_mid();
        test_ena_drop();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
